// File: rtl/bsg_fifo_1r1w_small_count.sv
// Small register-file FIFO with occupancy count, almost-full/empty flags, flush and sticky error.
// Optional zero-latency bypass while empty: define BSG_FIFO_SMALL_COUNT_BYPASS_EN.
module bsg_fifo_1r1w_small_count #(
    parameter int width_p            = 32,
    parameter int els_p              = 4,
    parameter int ready_THEN_valid_p = 0,
    parameter int almost_full_p      = els_p - 1,
    parameter int almost_empty_p     = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [width_p-1:0]           data_i,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         err_o
);

    localparam int ptr_w = ($clog2(els_p) > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] els_c    = cnt_w'(els_p);
    localparam logic [cnt_w-1:0] af_c     = cnt_w'(almost_full_p);
    localparam logic [cnt_w-1:0] ae_c     = cnt_w'(almost_empty_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [cnt_w-1:0]   count;
    logic               err;

    logic full;
    logic empty;
    logic bypass;
    logic take;
    logic enq_req;
    logic deq_req;
    logic enq;
    logic deq;
    logic illegal;

    assign full  = (count == els_c);
    assign empty = (count == '0);

    assign ready_o = ~full & ~reset_i;

`ifdef BSG_FIFO_SMALL_COUNT_BYPASS_EN
    // While empty, the incoming word is presented directly; if taken the same cycle it never lands in the array.
    assign bypass = empty & v_i & ~reset_i;
    assign v_o    = ~empty | bypass;
    assign data_o = bypass ? data_i : mem[rptr];
    assign take   = bypass & yumi_i;
`else
    assign bypass = 1'b0;
    assign v_o    = ~empty;
    assign data_o = mem[rptr];
    assign take   = 1'b0;
`endif

    assign enq_req = (ready_THEN_valid_p != 0) ? (v_i & ~full) : (v_i & ready_o);
    assign deq_req = yumi_i & v_o;
    assign enq     = enq_req & ~take;
    assign deq     = deq_req & ~take;

    // In ready-then-valid mode a producer must never present while full; yumi needs a valid head.
    assign illegal = ((ready_THEN_valid_p != 0) & v_i & full) | (yumi_i & ~v_o);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= (wptr == last_ptr) ? '0 : wptr + 1'b1;
            end
            if (deq) begin
                rptr <= (rptr == last_ptr) ? '0 : rptr + 1'b1;
            end
            if (enq & ~deq) begin
                count <= count + 1'b1;
            end else if (deq & ~enq) begin
                count <= count - 1'b1;
            end
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (enq & ~flush_i & ~reset_i) begin
            mem[wptr] <= data_i;
        end
    end

    assign count_o        = count;
    assign almost_full_o  = (count >= af_c);
    assign almost_empty_o = (count <= ae_c);
    assign err_o          = err;

    logic unused_bypass;
    assign unused_bypass = bypass;

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_count.sv
// Directed bench for bsg_fifo_1r1w_small_count: one valid-and-ready instance, one ready-then-valid instance.
module tb_bsg_fifo_1r1w_small_count;

    logic       clk;
    logic       reset_i;
    logic       flush_i, v_i, yumi_i;
    logic [7:0] data_i;
    logic       ready_o, v_o, almost_full_o, almost_empty_o, err_o;
    logic [7:0] data_o;
    logic [1:0] count_o;

    logic       r_flush, r_v, r_yumi;
    logic [7:0] r_data_i;
    logic       r_ready, r_v_o, r_af, r_ae, r_err;
    logic [7:0] r_data_o;
    logic [1:0] r_count;

    int total = 0;
    int bad   = 0;

    bsg_fifo_1r1w_small_count #(
        .width_p(8), .els_p(3), .ready_THEN_valid_p(0), .almost_full_p(2), .almost_empty_p(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .count_o(count_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o), .err_o(err_o)
    );

    bsg_fifo_1r1w_small_count #(
        .width_p(8), .els_p(3), .ready_THEN_valid_p(1), .almost_full_p(2), .almost_empty_p(1)
    ) dut_rtv (
        .clk_i(clk), .reset_i(reset_i), .flush_i(r_flush), .v_i(r_v), .ready_o(r_ready),
        .data_i(r_data_i), .v_o(r_v_o), .data_o(r_data_o), .yumi_i(r_yumi), .count_o(r_count),
        .almost_full_o(r_af), .almost_empty_o(r_ae), .err_o(r_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        total++; if (almost_empty_o !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty_o); end
        total++; if (almost_full_o !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
        total++; if (r_ready !== 1'b1) begin bad++; $display("FAIL reset_rtv_ready got=%b exp=1", r_ready); end
    endtask

    task automatic test_reset_midstream();
        v_i = 1'b1; data_i = 8'h01;
        tick();
        data_i = 8'h02;
        tick();
        v_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", count_o); end
        #1;
        reset_i = 1'b1;
        #1;
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", count_o); end
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL mid_rst_v_o got=%b exp=0", v_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", ready_o); end
        total++; if (almost_empty_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ae got=%b exp=1", almost_empty_o); end
        #1;
        reset_i = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b exp=1", ready_o); end
        v_i = 1'b1; data_i = 8'hA1;
        tick();
        v_i = 1'b0;
        #1;
        total++; if (v_o !== 1'b1) begin bad++; $display("FAIL mid_a1_v_o got=%b exp=1", v_o); end
        total++; if (data_o !== 8'hA1) begin bad++; $display("FAIL mid_a1_data got=%h exp=a1", data_o); end
        total++; if (count_o !== 2'd1) begin bad++; $display("FAIL mid_a1_count got=%0d exp=1", count_o); end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL mid_pop_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_fill_wrap();
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        v_i = 1'b1; data_i = 8'h11;
        tick();
        total++; if (count_o !== 2'd1) begin bad++; $display("FAIL fill1_count got=%0d exp=1", count_o); end
        total++; if (almost_empty_o !== 1'b1) begin bad++; $display("FAIL fill1_ae got=%b exp=1", almost_empty_o); end
        total++; if (almost_full_o !== 1'b0) begin bad++; $display("FAIL fill1_af got=%b exp=0", almost_full_o); end
        data_i = 8'h22;
        tick();
        total++; if (almost_full_o !== 1'b1) begin bad++; $display("FAIL fill2_af got=%b exp=1", almost_full_o); end
        total++; if (almost_empty_o !== 1'b0) begin bad++; $display("FAIL fill2_ae got=%b exp=0", almost_empty_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL fill2_ready got=%b exp=1", ready_o); end
        data_i = 8'h33;
        tick();
        total++; if (count_o !== 2'd3) begin bad++; $display("FAIL fill3_count got=%0d exp=3", count_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL fill3_ready got=%b exp=0", ready_o); end
        // valid while full in valid-and-ready mode is simply not accepted
        data_i = 8'h99;
        tick();
        v_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd3) begin bad++; $display("FAIL full_hold_count got=%0d exp=3", count_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL full_rav_err got=%b exp=0", err_o); end
        total++; if (data_o !== 8'h11) begin bad++; $display("FAIL full_head got=%h exp=11", data_o); end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        v_i = 1'b1; data_i = 8'h44;
        tick();
        v_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", count_o); end
        total++; if (data_o !== 8'h22) begin bad++; $display("FAIL wrap_pop0 got=%h exp=22", data_o); end
        yumi_i = 1'b1;
        tick();
        total++; if (data_o !== 8'h33) begin bad++; $display("FAIL wrap_pop1 got=%h exp=33", data_o); end
        tick();
        total++; if (data_o !== 8'h44) begin bad++; $display("FAIL wrap_pop2 got=%h exp=44", data_o); end
        tick();
        yumi_i = 1'b0;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL wrap_empty_v got=%b exp=0", v_o); end
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL wrap_empty_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [7];
        seq[0] = 8'h30; seq[1] = 8'h31;
        for (int i = 2; i < 7; i++) seq[i] = 8'h40 + 8'(i - 2);
        v_i = 1'b1; data_i = seq[0];
        tick();
        data_i = seq[1];
        tick();
        for (int i = 0; i < 5; i++) begin
            data_i = seq[i + 2]; yumi_i = 1'b1;
            #1;
            total++; if (data_o !== seq[i]) begin bad++; $display("FAIL b2b_head%0d got=%h exp=%h", i, data_o, seq[i]); end
            tick();
            total++; if (count_o !== 2'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count_o); end
        end
        v_i = 1'b0;
        for (int i = 5; i < 7; i++) begin
            #1;
            total++; if (data_o !== seq[i]) begin bad++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, data_o, seq[i]); end
            tick();
        end
        yumi_i = 1'b0;
        #1;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err_o); end
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL b2b_end_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_rtv_overflow();
        r_v = 1'b1; r_data_i = 8'h01;
        tick();
        r_data_i = 8'h02;
        tick();
        r_data_i = 8'h03;
        tick();
        total++; if (r_count !== 2'd3) begin bad++; $display("FAIL rtv_full_count got=%0d exp=3", r_count); end
        total++; if (r_err !== 1'b0) begin bad++; $display("FAIL rtv_pre_err got=%b exp=0", r_err); end
        r_data_i = 8'h55;
        tick();
        r_v = 1'b0;
        #1;
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL rtv_err_set got=%b exp=1", r_err); end
        total++; if (r_count !== 2'd3) begin bad++; $display("FAIL rtv_drop_count got=%0d exp=3", r_count); end
        total++; if (r_data_o !== 8'h01) begin bad++; $display("FAIL rtv_head got=%h exp=01", r_data_o); end
        r_yumi = 1'b1;
        tick();
        r_yumi = 1'b0;
        #1;
        total++; if (r_data_o !== 8'h02) begin bad++; $display("FAIL rtv_head2 got=%h exp=02", r_data_o); end
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL rtv_err_sticky got=%b exp=1", r_err); end
        // a push offered during the flush cycle must be discarded
        r_flush = 1'b1; r_v = 1'b1; r_data_i = 8'h66;
        tick();
        r_flush = 1'b0; r_v = 1'b0;
        #1;
        total++; if (r_count !== 2'd0) begin bad++; $display("FAIL rtv_flush_count got=%0d exp=0", r_count); end
        total++; if (r_err !== 1'b0) begin bad++; $display("FAIL rtv_flush_err got=%b exp=0", r_err); end
        total++; if (r_v_o !== 1'b0) begin bad++; $display("FAIL rtv_flush_v got=%b exp=0", r_v_o); end
    endtask

    task automatic test_yumi_empty();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        #1;
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL yumi_empty_err got=%b exp=1", err_o); end
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL yumi_empty_count got=%0d exp=0", count_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL yumi_flush_err got=%b exp=0", err_o); end
    endtask

    task automatic test_bypass();
`ifdef BSG_FIFO_SMALL_COUNT_BYPASS_EN
        v_i = 1'b1; data_i = 8'h7E; yumi_i = 1'b1;
        #1;
        total++; if (v_o !== 1'b1) begin bad++; $display("FAIL byp_v_o got=%b exp=1", v_o); end
        total++; if (data_o !== 8'h7E) begin bad++; $display("FAIL byp_data got=%h exp=7e", data_o); end
        tick();
        v_i = 1'b0; yumi_i = 1'b0;
        #1;
        total++; if (count_o !== 2'd0) begin bad++; $display("FAIL byp_count got=%0d exp=0", count_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL byp_err got=%b exp=0", err_o); end
`else
        v_i = 1'b1; data_i = 8'h7E;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL nobyp_v_o got=%b exp=0", v_o); end
        tick();
        v_i = 1'b0;
        #1;
        total++; if (data_o !== 8'h7E) begin bad++; $display("FAIL nobyp_data got=%h exp=7e", data_o); end
        total++; if (count_o !== 2'd1) begin bad++; $display("FAIL nobyp_count got=%0d exp=1", count_o); end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        #1;
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL nobyp_err got=%b exp=0", err_o); end
`endif
    endtask

    initial begin
        reset_i = 1'b1;
        flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        r_flush = 1'b0; r_v = 1'b0; r_yumi = 1'b0; r_data_i = '0;
        test_reset();
        test_reset_midstream();
        test_fill_wrap();
        test_back_to_back();
        test_rtv_overflow();
        test_yumi_empty();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_1r1w_small_count.md
Name: bsg_fifo_1r1w_small_count

Overview:
- Small register-file FIFO: 1 write port, 1 asynchronous read port, valid-yumi output.
- Next generation of the small FIFO: adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky protocol-error flag.
- Supports non-power-of-two depths.
- Used at ingress/egress of hash-core pipelines, where producers need early back-pressure and credit visibility.

Parameters:
- width_p, 32: data width in bits, >=1.
- els_p, 4: entries, >=2, any integer (non-power-of-two allowed).
- ready_THEN_valid_p, 0: 0 = valid-and-ready input handshake; 1 = ready-then-valid input handshake.
- almost_full_p, els_p-1: almost_full_o threshold, 1..els_p.
- almost_empty_p, 1: almost_empty_o threshold, 0..els_p-1.

Ports:
- clk_i, in, 1: clock, all state on posedge.
- reset_i, in, 1: asynchronous, active-high reset.
- flush_i, in, 1: synchronous clear of contents.
- v_i, in, 1: input valid.
- ready_o, out, 1: space available.
- data_i, in, width_p: write data.
- v_o, out, 1: output valid.
- data_o, out, width_p: head entry.
- yumi_i, in, 1: consumer takes head this cycle.
- count_o, out, clog2(els_p+1): entries held.
- almost_full_o, out, 1: count_o >= almost_full_p.
- almost_empty_o, out, 1: count_o <= almost_empty_p.
- err_o, out, 1: sticky protocol error.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - wptr, rptr, count, err go to 0.
  - Storage array is not reset.
  - While reset_i=1: v_o=0, ready_o=0, count_o=0, almost_full_o=0, almost_empty_o=1, err_o=0.
  - After release: ready_o=1 in the same cycle reset_i falls.
- Status decode: full = (count==els_p), empty = (count==0).
  - ready_o = ~full & ~reset_i.
  - v_o = ~empty.
- Enqueue:
  - rav mode: enq = v_i & ready_o.
  - rtv mode: enq = v_i & ~full. A v_i while full is dropped, the array is not written, and err is set.
- Dequeue:
  - deq = yumi_i & v_o.
  - yumi_i while empty is ignored and sets err.
- Write and read paths:
  - Write at wptr on posedge when enq.
  - data_o = mem[rptr], asynchronous read.
  - Enqueue-to-v_o latency is 1 cycle.
- Pointers: increment on enq / deq; wrap from els_p-1 to 0 (explicit compare, not power-of-two truncation).
- count next value: enq&~deq -> +1; deq&~enq -> -1; both or neither -> hold.
- Simultaneous enq and deq:
  - When full: rav mode cannot enq (ready_o=0).
  - When empty: deq is illegal (v_o=0); enq proceeds.
  - Mid-range: count holds and both pointers advance.
- Flags are pure decodes of the count register, so they change one cycle after the causing handshake.
- flush_i (priority over enq/deq):
  - Next edge clears pointers, count and err.
  - Enq/deq in the flush cycle is discarded.
  - ready_o and v_o are evaluated normally during the flush cycle.
- err: set on any illegal event listed above; holds until reset_i or flush_i.
- Pointer width is clog2(els_p), minimum 1 bit.

Optional Feature:
- Macro: BSG_FIFO_SMALL_COUNT_BYPASS_EN.
- Defined (zero-latency bypass while empty):
  - When count==0 and v_i=1 (and reset_i=0), v_o=1 and data_o=data_i combinationally.
  - If yumi_i is also 1, the word is consumed directly: no write, pointers and count unchanged.
  - If yumi_i=0, the word is written normally.
  - yumi_i while empty with v_i=1 is legal and does not set err.
- Undefined: no combinational path from v_i/data_i to v_o/data_o; latency exactly 1 cycle.

Test Plan (width_p=8, els_p=3, almost_full_p=2, almost_empty_p=1, rav mode unless noted):
1. Reset mid-stream: hold count=2, assert reset_i between edges -> count_o=0, v_o=0, ready_o=0 immediately; after release, first push 0xA1 appears on data_o next cycle.
2. Fill and wrap: push 0x11,0x22,0x33 -> ready_o=0, count_o=3, almost_full_o=1 after 2nd push. Pop one and push 0x44 -> pops return 0x22,0x33,0x44 in order (wptr wrapped 2->0).
3. Simultaneous enq/deq at count=2 for 5 cycles -> count_o stays 2, output order matches input order, err_o=0.
4. rtv mode, full, v_i=1 with data 0x55 -> 0x55 not stored, err_o=1 next cycle and stays 1 until flush_i; then count_o=0 and err_o=0.
5. yumi_i at count=0 -> err_o=1, count_o remains 0 (bypass undefined).
6. Bypass defined, empty, v_i=1, data_i=0x7E, yumi_i=1 same cycle -> data_o=0x7E, v_o=1 that cycle, count_o stays 0, err_o=0.
